// File: rtl/clk_align_ctrl_if.sv
// clk_align_ctrl_if: PLL lock, sampler status and PHY bring-up signals of the
// eclksync phase-alignment controller.
interface clk_align_ctrl_if;
    logic       pll_lock;
    logic       realign;
    logic [1:0] align_status;
    logic       eclksync_stop;
    logic       ddr_reset;
    logic       phase_step;
    logic       aligned;
    logic       fail;
    logic [7:0] step_count;

    modport master (
        input  pll_lock, realign, align_status,
        output eclksync_stop, ddr_reset, phase_step, aligned, fail, step_count
    );
    modport slave (
        output pll_lock, realign, align_status,
        input  eclksync_stop, ddr_reset, phase_step, aligned, fail, step_count
    );
endinterface

// File: rtl/clk_align_ctrl.sv
// clk_align_ctrl: restarts the eclksync divider, then steps PLL phase until the
// filtered sampler status shows the 00 -> 01 transition, reporting aligned or fail.
module clk_align_ctrl #(
    parameter int STOP_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int FILTER        = 3,
    parameter int MAX_STEPS     = 64
) (
    input logic              sclk,
    input logic              reset_n,
    clk_align_ctrl_if.master bus
);
    typedef enum logic [3:0] {IDLE, STOP, RELEASE, SETTLE, SAMPLE, EVAL, STEP, DONE, FAIL} state_t;

    state_t      state_q, state_d;
    logic        lock_m_q, lock_s_q;
    logic [1:0]  status_q, last_q;
    logic [1:0]  cur_q, cur_d, prev_q, prev_d;
    logic        prev_valid_q, prev_valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  filt_q, filt_d;
    logic [7:0]  step_q, step_d;
    logic        hit;

    assign hit = prev_valid_q && prev_q == 2'b00 && cur_q == 2'b01;

    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lock_m_q     <= 1'b0;
            lock_s_q     <= 1'b0;
            status_q     <= '0;
            last_q       <= '0;
            cur_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            cnt_q        <= '0;
            filt_q       <= '0;
            step_q       <= '0;
        end else begin
            state_q      <= state_d;
            lock_m_q     <= bus.pll_lock;
            lock_s_q     <= lock_m_q;
            status_q     <= bus.align_status;
            last_q       <= status_q;
            cur_q        <= cur_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            cnt_q        <= cnt_d;
            filt_q       <= filt_d;
            step_q       <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = lock_s_q ? STOP : IDLE;
            STOP:     state_d = (cnt_q == 16'(STOP_CYCLES - 1)) ? RELEASE : STOP;
            RELEASE:  state_d = (cnt_q == 16'(STOP_CYCLES - 1)) ? SETTLE : RELEASE;
            SETTLE:   state_d = (cnt_q == 16'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
            SAMPLE:   state_d = (filt_d == 4'(FILTER)) ? EVAL : SAMPLE;
            EVAL:     state_d = hit ? DONE : (step_q == 8'(MAX_STEPS)) ? FAIL : STEP;
            STEP:     state_d = SETTLE;
            DONE:     state_d = bus.realign ? STOP : DONE;
            FAIL:     state_d = bus.realign ? STOP : FAIL;
            default:  state_d = IDLE;
        endcase
        // Lock loss outranks everything, including a pending realign.
        if (!lock_s_q) state_d = IDLE;
    end

    always_comb begin
        cnt_d        = (state_d == state_q) ? cnt_q + 16'd1 : '0;
        filt_d       = (state_q != SAMPLE) ? '0 : (status_q == last_q) ? filt_q + 4'd1 : 4'd1;
        cur_d        = (state_q == SAMPLE) ? status_q : cur_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        step_d       = (state_q == STEP) ? step_q + 8'd1 : step_q;
        if (state_q == EVAL && state_d == STEP) begin
            prev_d       = cur_q;
            prev_valid_d = 1'b1;
        end
        if (state_d == IDLE || state_d == STOP) begin
            step_d       = '0;
            prev_valid_d = 1'b0;
        end
    end

    always_comb begin
        bus.eclksync_stop = state_q inside {STOP, RELEASE};
        bus.ddr_reset     = state_q inside {IDLE, STOP};
        bus.phase_step    = state_q == STEP;
        bus.aligned       = state_q == DONE;
        bus.fail          = state_q == FAIL;
        bus.step_count    = step_q;
    end
endmodule

// File: tb/tb_clk_align_ctrl.sv
// tb_clk_align_ctrl: directed scenarios against a table-driven phase sampler model
// whose status advances one entry per phase_step pulse.
module tb_clk_align_ctrl;
    logic sclk = 1'b0;
    logic reset_n = 1'b0;
    clk_align_ctrl_if bus();
    clk_align_ctrl #(.MAX_STEPS(8)) dut (.sclk(sclk), .reset_n(reset_n), .bus(bus));

    always #5 sclk = ~sclk;

    int         checks = 0;
    int         fails = 0;
    int         pulses = 0;
    int         base = 0;
    bit         consec_err = 1'b0;
    bit         prev_ps = 1'b0;
    logic [1:0] tab [0:15];
    int         idx = 0;
    bit         ovr_en = 1'b0;
    logic [1:0] ovr_val = 2'b00;

    assign bus.align_status = ovr_en ? ovr_val : tab[idx];

    always @(negedge sclk) begin
        if (bus.phase_step === 1'b1) begin
            pulses <= pulses + 1;
            if (prev_ps) consec_err <= 1'b1;
        end
        prev_ps <= (bus.phase_step === 1'b1);
    end

    // Sampler model: each phase step moves to the next table entry.
    always @(posedge sclk)
        if (bus.realign === 1'b1 || bus.pll_lock !== 1'b1) idx <= 0;
        else if (bus.phase_step === 1'b1 && idx < 15) idx <= idx + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic load(input logic [15:0] seq, input logic [1:0] fill);
        for (int i = 0; i < 8; i++) tab[i] = seq[15 - 2*i -: 2];
        for (int i = 8; i < 16; i++) tab[i] = fill;
    endtask

    task automatic wait_end(input int max);
        for (int i = 0; i < max && !(bus.aligned === 1'b1 || bus.fail === 1'b1); i++) @(negedge sclk);
    endtask

    task automatic pulse_realign;
        bus.realign = 1'b1;
        @(negedge sclk);
        bus.realign = 1'b0;
    endtask

    task automatic test_reset;
        bus.pll_lock = 1'b0;
        bus.realign = 1'b0;
        load({8{2'b00}}, 2'b00);
        reset_n = 1'b0;
        tick(3);
        checks++;
        if ({bus.eclksync_stop, bus.ddr_reset, bus.phase_step, bus.aligned, bus.fail} !== 5'b01000 || bus.step_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_values: got stop/rst/ps/al/fl=%b step=%0d expected 01000 step=0",
                     {bus.eclksync_stop, bus.ddr_reset, bus.phase_step, bus.aligned, bus.fail}, bus.step_count);
        end
        reset_n = 1'b1;
        tick(5);
        checks++;
        if ({bus.eclksync_stop, bus.ddr_reset} !== 2'b01) begin
            fails++;
            $display("FAIL idle_no_lock: got stop/rst=%b expected 01", {bus.eclksync_stop, bus.ddr_reset});
        end
    endtask

    task automatic test_bringup_first_step;
        logic [2:0] e;
        load({2'b00, {7{2'b01}}}, 2'b01);
        base = pulses;
        bus.pll_lock = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            @(negedge sclk);
            e = {n >= 3 && n <= 10, n <= 6, n == 31};
            checks++;
            if ({bus.eclksync_stop, bus.ddr_reset, bus.phase_step} !== e) begin
                fails++;
                $display("FAIL bringup_seq cycle %0d: got stop/rst/ps=%b expected %b", n,
                         {bus.eclksync_stop, bus.ddr_reset, bus.phase_step}, e);
            end
        end
        wait_end(300);
        checks++;
        if ({bus.aligned, bus.fail} !== 2'b10 || bus.step_count !== 8'd1 || pulses - base != 1) begin
            fails++;
            $display("FAIL first_step_align: got al/fl=%b step=%0d pulses=%0d expected 10 step=1 pulses=1",
                     {bus.aligned, bus.fail}, bus.step_count, pulses - base);
        end
        tick(5);
        checks++;
        if (bus.aligned !== 1'b1 || bus.phase_step !== 1'b0) begin
            fails++;
            $display("FAIL done_hold: got al=%b ps=%b expected 1 0", bus.aligned, bus.phase_step);
        end
    endtask

    task automatic test_wrong_transitions;
        load({2'b01, 2'b11, 2'b10, 2'b00, {4{2'b01}}}, 2'b01);
        base = pulses;
        pulse_realign;
        checks++;
        if ({bus.eclksync_stop, bus.ddr_reset, bus.aligned, bus.fail} !== 4'b1100 || bus.step_count !== 8'd0) begin
            fails++;
            $display("FAIL realign_from_done: got stop/rst/al/fl=%b step=%0d expected 1100 step=0",
                     {bus.eclksync_stop, bus.ddr_reset, bus.aligned, bus.fail}, bus.step_count);
        end
        wait_end(500);
        checks++;
        if ({bus.aligned, bus.fail} !== 2'b10 || bus.step_count !== 8'd4 || pulses - base != 4) begin
            fails++;
            $display("FAIL wrong_transitions: got al/fl=%b step=%0d pulses=%0d expected 10 step=4 pulses=4",
                     {bus.aligned, bus.fail}, bus.step_count, pulses - base);
        end
    endtask

    task automatic test_glitch_filter;
        load({2'b01, 2'b00, {6{2'b01}}}, 2'b01);
        base = pulses;
        pulse_realign;
        for (int i = 0; i < 50 && bus.eclksync_stop !== 1'b0; i++) @(negedge sclk);
        // Toggle through the first five SAMPLE cycles, then hold 01.
        ovr_en = 1'b1;
        ovr_val = 2'b01;
        for (int n = 1; n <= 25; n++) begin
            @(negedge sclk);
            checks++;
            if (bus.phase_step !== (n == 25)) begin
                fails++;
                $display("FAIL glitch_filter cycle %0d: got ps=%b expected %b", n, bus.phase_step, n == 25);
            end
            ovr_val = (n + 1 <= 20 && (n + 1) % 2 == 0) ? 2'b00 : 2'b01;
        end
        ovr_en = 1'b0;
        wait_end(300);
        checks++;
        if ({bus.aligned, bus.fail} !== 2'b10 || bus.step_count !== 8'd2 || pulses - base != 2) begin
            fails++;
            $display("FAIL glitch_align: got al/fl=%b step=%0d pulses=%0d expected 10 step=2 pulses=2",
                     {bus.aligned, bus.fail}, bus.step_count, pulses - base);
        end
    endtask

    task automatic test_exhaustion;
        load({8{2'b10}}, 2'b10);
        base = pulses;
        pulse_realign;
        wait_end(600);
        checks++;
        if ({bus.aligned, bus.fail} !== 2'b01 || bus.step_count !== 8'd8 || pulses - base != 8) begin
            fails++;
            $display("FAIL exhaustion: got al/fl=%b step=%0d pulses=%0d expected 01 step=8 pulses=8",
                     {bus.aligned, bus.fail}, bus.step_count, pulses - base);
        end
        tick(4);
        checks++;
        if (bus.fail !== 1'b1 || bus.phase_step !== 1'b0) begin
            fails++;
            $display("FAIL fail_hold: got fl=%b ps=%b expected 1 0", bus.fail, bus.phase_step);
        end
        pulse_realign;
        checks++;
        if ({bus.eclksync_stop, bus.ddr_reset, bus.fail} !== 3'b110 || bus.step_count !== 8'd0) begin
            fails++;
            $display("FAIL realign_from_fail: got stop/rst/fl=%b step=%0d expected 110 step=0",
                     {bus.eclksync_stop, bus.ddr_reset, bus.fail}, bus.step_count);
        end
    endtask

    task automatic test_lock_loss;
        int k = 0;
        for (int i = 0; i < 500 && k < 3; i++) begin
            @(negedge sclk);
            if (bus.phase_step === 1'b1) k++;
        end
        tick(3);
        checks++;
        if (bus.step_count !== 8'd3 || {bus.eclksync_stop, bus.ddr_reset} !== 2'b00) begin
            fails++;
            $display("FAIL settle_after_3: got step=%0d stop/rst=%b expected step=3 00",
                     bus.step_count, {bus.eclksync_stop, bus.ddr_reset});
        end
        bus.pll_lock = 1'b0;
        tick(2);
        checks++;
        if (bus.ddr_reset !== 1'b0) begin
            fails++;
            $display("FAIL lock_sync_delay: got rst=%b expected 0", bus.ddr_reset);
        end
        tick(1);
        checks++;
        if ({bus.eclksync_stop, bus.ddr_reset, bus.aligned, bus.fail} !== 4'b0100 || bus.step_count !== 8'd0) begin
            fails++;
            $display("FAIL lock_loss_idle: got stop/rst/al/fl=%b step=%0d expected 0100 step=0",
                     {bus.eclksync_stop, bus.ddr_reset, bus.aligned, bus.fail}, bus.step_count);
        end
        load({2'b00, {7{2'b01}}}, 2'b01);
        base = pulses;
        tick(2);
        bus.pll_lock = 1'b1;
        tick(2);
        checks++;
        if (bus.eclksync_stop !== 1'b0) begin
            fails++;
            $display("FAIL relock_early: got stop=%b expected 0", bus.eclksync_stop);
        end
        tick(1);
        checks++;
        if ({bus.eclksync_stop, bus.ddr_reset} !== 2'b11) begin
            fails++;
            $display("FAIL relock_stop: got stop/rst=%b expected 11", {bus.eclksync_stop, bus.ddr_reset});
        end
        wait_end(300);
        checks++;
        if ({bus.aligned, bus.fail} !== 2'b10 || bus.step_count !== 8'd1 || pulses - base != 1) begin
            fails++;
            $display("FAIL relock_align: got al/fl=%b step=%0d pulses=%0d expected 10 step=1 pulses=1",
                     {bus.aligned, bus.fail}, bus.step_count, pulses - base);
        end
    endtask

    task automatic test_max_priority;
        load({{7{2'b10}}, 2'b00}, 2'b01);
        base = pulses;
        pulse_realign;
        wait_end(600);
        checks++;
        if ({bus.aligned, bus.fail} !== 2'b10 || bus.step_count !== 8'd8 || pulses - base != 8) begin
            fails++;
            $display("FAIL match_at_max: got al/fl=%b step=%0d pulses=%0d expected 10 step=8 pulses=8",
                     {bus.aligned, bus.fail}, bus.step_count, pulses - base);
        end
    endtask

    task automatic test_async_reset;
        pulse_realign;
        tick(1);
        checks++;
        if (bus.eclksync_stop !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_stop: got stop=%b expected 1", bus.eclksync_stop);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.eclksync_stop, bus.ddr_reset, bus.phase_step, bus.aligned, bus.fail} !== 5'b01000 || bus.step_count !== 8'd0) begin
            fails++;
            $display("FAIL async_reset: got stop/rst/ps/al/fl=%b step=%0d expected 01000 step=0",
                     {bus.eclksync_stop, bus.ddr_reset, bus.phase_step, bus.aligned, bus.fail}, bus.step_count);
        end
        tick(2);
        reset_n = 1'b1;
        tick(3);
        checks++;
        if ({bus.eclksync_stop, bus.ddr_reset} !== 2'b11) begin
            fails++;
            $display("FAIL restart_after_reset: got stop/rst=%b expected 11", {bus.eclksync_stop, bus.ddr_reset});
        end
    endtask

    initial begin
        test_reset;
        test_bringup_first_step;
        test_wrong_transitions;
        test_glitch_filter;
        test_exhaustion;
        test_lock_loss;
        test_max_priority;
        test_async_reset;
        checks++;
        if (consec_err !== 1'b0) begin
            fails++;
            $display("FAIL step_spacing: got back-to-back phase_step=%b expected 0", consec_err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
